// File: rtl/bounce_square.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_square
//  Description : Draws a square that bounces off the edges of the active area.
//                The position is updated once per frame during vertical
//                blanking. Pixels go through a two-stage pipeline, so every
//                output lags its inputs by exactly two pixel clocks.
//  Revision    : 1.0  initial release
// ============================================================================
module bounce_square #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int Q_SIZE = 32,
    parameter int SPEED  = 2
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       de,
    input  logic       run,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic [7:0] frame_cnt
);

    // All position arithmetic is 11 bits wide so that qx+Q_SIZE cannot wrap.
    localparam logic [10:0] c_X_LIM  = 11'(H_RES - Q_SIZE);
    localparam logic [10:0] c_Y_LIM  = 11'(V_RES - Q_SIZE);
    localparam logic [10:0] c_SPD    = 11'(SPEED);
    localparam logic [10:0] c_QSZ    = 11'(Q_SIZE);
    localparam logic [9:0]  c_V_TICK = 10'(V_RES);

    // Square state and frame bookkeeping
    logic [9:0]  r_qx;
    logic [9:0]  r_qy;
    logic        r_dx;
    logic        r_dy;
    logic [7:0]  r_frame_cnt;
    logic        r_frame_tick;

    // Pipeline stage 1
    logic        r_s1_de;
    logic        r_s1_hsync;
    logic        r_s1_vsync;
    logic        r_s1_in_sq;

    // Pipeline stage 2
    logic [11:0] r_colour;
    logic        r_s2_hsync;
    logic        r_s2_vsync;

    logic [10:0] w_sx;
    logic [10:0] w_sy;
    logic [10:0] w_qx;
    logic [10:0] w_qy;
    logic        w_in_sq;
    logic [10:0] w_qx_nxt;
    logic [10:0] w_qy_nxt;
    logic        w_dx_nxt;
    logic        w_dy_nxt;
    logic [11:0] w_colour;

    // One axis of motion: step by SPEED, clamp to the edge and reverse there.
    function automatic logic [11:0] f_step(input logic [10:0] q,
                                           input logic        d,
                                           input logic [10:0] lim);
        logic [10:0] q_n;
        logic        d_n;
        q_n = q;
        d_n = d;
        if (d) begin
            if (q >= lim - c_SPD) begin
                q_n = lim;
                d_n = 1'b0;
            end else begin
                q_n = q + c_SPD;
            end
        end else begin
            if (q <= c_SPD) begin
                q_n = 11'd0;
                d_n = 1'b1;
            end else begin
                q_n = q - c_SPD;
            end
        end
        return {d_n, q_n};
    endfunction

    assign w_sx = {1'b0, sx};
    assign w_sy = {1'b0, sy};
    assign w_qx = {1'b0, r_qx};
    assign w_qy = {1'b0, r_qy};

    // Pixel-inside-square test and next position for the coming frame tick.
    always_comb begin
        w_in_sq = (w_sx >= w_qx) && (w_sx < w_qx + c_QSZ) &&
                  (w_sy >= w_qy) && (w_sy < w_qy + c_QSZ);
        {w_dx_nxt, w_qx_nxt} = f_step(w_qx, r_dx, c_X_LIM);
        {w_dy_nxt, w_qy_nxt} = f_step(w_qy, r_dy, c_Y_LIM);
    end

    // Frame tick from the first blanking line, frame counter and motion.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= 8'd0;
            r_qx         <= 10'd0;
            r_qy         <= 10'd0;
            r_dx         <= 1'b1;
            r_dy         <= 1'b1;
        end else begin
            r_frame_tick <= (sy == c_V_TICK) && (sx == 10'd0);
            if (r_frame_tick) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (r_frame_tick && run) begin
                r_qx <= w_qx_nxt[9:0];
                r_qy <= w_qy_nxt[9:0];
                r_dx <= w_dx_nxt;
                r_dy <= w_dy_nxt;
            end
        end
    end

    // Stage 1: capture timing and the inside-square decision.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_s1_de    <= 1'b0;
            r_s1_hsync <= 1'b1;
            r_s1_vsync <= 1'b1;
            r_s1_in_sq <= 1'b0;
        end else begin
            r_s1_de    <= de;
            r_s1_hsync <= hsync;
            r_s1_vsync <= vsync;
            r_s1_in_sq <= w_in_sq;
        end
    end

    // Colour choice: black in blanking, palette on the square, background else.
    always_comb begin
        w_colour = 12'h000;
        if (r_s1_de) begin
            if (r_s1_in_sq) begin
                case (r_frame_cnt[5:4])
                    2'd0:    w_colour = 12'hFFF;
                    2'd1:    w_colour = 12'hF40;
                    2'd2:    w_colour = 12'h4F4;
                    default: w_colour = 12'h4CF;
                endcase
            end else begin
                w_colour = 12'h137;
            end
        end
    end

    // Stage 2: registered colour and syncs drive every output.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            r_colour   <= 12'h000;
            r_s2_hsync <= 1'b1;
            r_s2_vsync <= 1'b1;
        end else begin
            r_colour   <= w_colour;
            r_s2_hsync <= r_s1_hsync;
            r_s2_vsync <= r_s1_vsync;
        end
    end

    assign vga_r     = r_colour[11:8];
    assign vga_g     = r_colour[7:4];
    assign vga_b     = r_colour[3:0];
    assign vga_hsync = r_s2_hsync;
    assign vga_vsync = r_s2_vsync;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bounce_square.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bounce_square
//  Description : Directed self-checking bench for bounce_square. Frame ticks
//                are produced by jumping the timing inputs straight to the
//                first blanking line instead of scanning whole frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bounce_square;

    logic       clk_pix = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sx = 10'd799;
    logic [9:0] sy = 10'd524;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic       de = 1'b0;
    logic       run = 1'b0;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       vga_hsync;
    logic       vga_vsync;
    logic [7:0] frame_cnt;

    int nvec = 0;
    int nerr = 0;
    int exp_cnt = 0;
    logic [11:0] pal [4] = '{12'hFFF, 12'hF40, 12'h4F4, 12'h4CF};

    bounce_square dut (
        .clk_pix   (clk_pix),
        .rst       (rst),
        .sx        (sx),
        .sy        (sy),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .run       (run),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .frame_cnt (frame_cnt)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic drive(input int x, input int y, input logic d,
                         input logic hs, input logic vs);
        sx    = x[9:0];
        sy    = y[9:0];
        de    = d;
        hsync = hs;
        vsync = vs;
    endtask

    // One frame tick: condition cycle, then the tick cycle that applies it.
    task automatic frame();
        drive(0, 480, 1'b0, 1'b1, 1'b1);
        step();
        drive(1, 480, 1'b0, 1'b1, 1'b1);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(799, 524, 1'b0, 1'b1, 1'b1);
        step();
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
            nerr++;
            $display("FAIL reset_out: colour=%h hs=%b vs=%b required 000 1 1",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync);
        end
        nvec++;
        if (frame_cnt !== 8'd0 || dut.r_qx !== 10'd0 || dut.r_qy !== 10'd0 ||
            dut.r_dx !== 1'b1 || dut.r_dy !== 1'b1) begin
            nerr++;
            $display("FAIL reset_state: cnt=%0d qx=%0d qy=%0d dx=%b dy=%b required 0 0 0 1 1",
                     frame_cnt, dut.r_qx, dut.r_qy, dut.r_dx, dut.r_dy);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        run = 1'b0;
        drive(799, 524, 1'b0, 1'b1, 1'b1);
        step();
        step();
        drive(0, 0, 1'b1, 1'b1, 1'b1);
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            nerr++;
            $display("FAIL lat_early: colour=%h required 000", {vga_r, vga_g, vga_b});
        end
        drive(32, 0, 1'b1, 1'b1, 1'b1);
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'hFFF) begin
            nerr++;
            $display("FAIL lat_pix00: colour=%h required fff", {vga_r, vga_g, vga_b});
        end
        drive(656, 0, 1'b0, 1'b0, 1'b1);
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h137 || vga_hsync !== 1'b1) begin
            nerr++;
            $display("FAIL lat_pix32: colour=%h hs=%b required 137 1",
                     {vga_r, vga_g, vga_b}, vga_hsync);
        end
        drive(700, 0, 1'b0, 1'b0, 1'b1);
        step();
        nvec++;
        if (vga_hsync !== 1'b0 || {vga_r, vga_g, vga_b} !== 12'h000) begin
            nerr++;
            $display("FAIL lat_hsync: hs=%b colour=%h required 0 000",
                     vga_hsync, {vga_r, vga_g, vga_b});
        end
        drive(701, 0, 1'b0, 1'b1, 1'b1);
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_vsync !== 1'b1) begin
            nerr++;
            $display("FAIL blank_700: colour=%h vs=%b required 000 1",
                     {vga_r, vga_g, vga_b}, vga_vsync);
        end
    endtask

    task automatic test_motion();
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            frame();
            nvec++;
            if (dut.r_qx !== 10'(2 * i) || dut.r_qy !== 10'(2 * i) || frame_cnt !== 8'(i)) begin
                nerr++;
                $display("FAIL motion_%0d: qx=%0d qy=%0d cnt=%0d required %0d %0d %0d",
                         i, dut.r_qx, dut.r_qy, frame_cnt, 2 * i, 2 * i, i);
            end
        end
    endtask

    task automatic test_bounce();
        // Frames 4..223: qy climbs to 446 still heading down.
        for (int i = 4; i <= 223; i++) frame();
        nvec++;
        if (dut.r_qy !== 10'd446 || dut.r_dy !== 1'b1) begin
            nerr++;
            $display("FAIL bottom_pre: qy=%0d dy=%b required 446 1", dut.r_qy, dut.r_dy);
        end
        frame();
        nvec++;
        if (dut.r_qy !== 10'd448 || dut.r_dy !== 1'b0) begin
            nerr++;
            $display("FAIL bottom_hit: qy=%0d dy=%b required 448 0", dut.r_qy, dut.r_dy);
        end
        frame();
        nvec++;
        if (dut.r_qy !== 10'd446) begin
            nerr++;
            $display("FAIL bottom_back: qy=%0d required 446", dut.r_qy);
        end
        for (int i = 226; i <= 303; i++) frame();
        nvec++;
        if (dut.r_qx !== 10'd606 || dut.r_dx !== 1'b1 || dut.r_qy !== 10'd290) begin
            nerr++;
            $display("FAIL right_pre: qx=%0d dx=%b qy=%0d required 606 1 290",
                     dut.r_qx, dut.r_dx, dut.r_qy);
        end
        frame();
        nvec++;
        if (dut.r_qx !== 10'd608 || dut.r_dx !== 1'b0) begin
            nerr++;
            $display("FAIL right_hit: qx=%0d dx=%b required 608 0", dut.r_qx, dut.r_dx);
        end
        frame();
        nvec++;
        if (dut.r_qx !== 10'd606 || dut.r_qy !== 10'd286 || frame_cnt !== 8'd49) begin
            nerr++;
            $display("FAIL right_back: qx=%0d qy=%0d cnt=%0d required 606 286 49",
                     dut.r_qx, dut.r_qy, frame_cnt);
        end
    endtask

    task automatic test_pause_wrap();
        exp_cnt = 49;
        // run drops exactly on the tick cycle: no motion, counter still moves.
        run = 1'b1;
        drive(0, 480, 1'b0, 1'b1, 1'b1);
        step();
        run = 1'b0;
        drive(1, 480, 1'b0, 1'b1, 1'b1);
        step();
        exp_cnt = exp_cnt + 1;
        nvec++;
        if (dut.r_qx !== 10'd606 || dut.r_qy !== 10'd286 || frame_cnt !== 8'(exp_cnt)) begin
            nerr++;
            $display("FAIL run_edge: qx=%0d qy=%0d cnt=%0d required 606 286 %0d",
                     dut.r_qx, dut.r_qy, frame_cnt, exp_cnt);
        end
        for (int i = 2; i <= 300; i++) begin
            frame();
            exp_cnt = (exp_cnt + 1) % 256;
            nvec++;
            if (frame_cnt !== 8'(exp_cnt)) begin
                nerr++;
                $display("FAIL cnt_wrap: frame %0d cnt=%0d required %0d", i, frame_cnt, exp_cnt);
            end
            drive(606, 286, 1'b1, 1'b1, 1'b1);
            step();
            drive(0, 481, 1'b0, 1'b1, 1'b1);
            step();
            nvec++;
            if ({vga_r, vga_g, vga_b} !== pal[exp_cnt[5:4]]) begin
                nerr++;
                $display("FAIL palette: cnt=%0d colour=%h required %h",
                         exp_cnt, {vga_r, vga_g, vga_b}, pal[exp_cnt[5:4]]);
            end
        end
        nvec++;
        if (dut.r_qx !== 10'd606 || dut.r_qy !== 10'd286 || frame_cnt !== 8'd93) begin
            nerr++;
            $display("FAIL pause_hold: qx=%0d qy=%0d cnt=%0d required 606 286 93",
                     dut.r_qx, dut.r_qy, frame_cnt);
        end
        // Square edges: columns 605 and 638 outside, 637 inside (cnt 93 -> index 1).
        drive(605, 286, 1'b1, 1'b1, 1'b1);
        step();
        drive(637, 317, 1'b1, 1'b1, 1'b1);
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h137) begin
            nerr++;
            $display("FAIL edge_left: colour=%h required 137", {vga_r, vga_g, vga_b});
        end
        drive(638, 286, 1'b1, 1'b1, 1'b1);
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'hF40) begin
            nerr++;
            $display("FAIL edge_in: colour=%h required f40", {vga_r, vga_g, vga_b});
        end
        drive(606, 318, 1'b1, 1'b1, 1'b1);
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h137) begin
            nerr++;
            $display("FAIL edge_right: colour=%h required 137", {vga_r, vga_g, vga_b});
        end
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h137) begin
            nerr++;
            $display("FAIL edge_bottom: colour=%h required 137", {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_async_reset();
        drive(100, 200, 1'b1, 1'b0, 1'b0);
        step();
        step();
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h137 || vga_hsync !== 1'b0 || vga_vsync !== 1'b0) begin
            nerr++;
            $display("FAIL areset_pre: colour=%h hs=%b vs=%b required 137 0 0",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync);
        end
        #2;
        rst = 1'b1;
        #1;
        nvec++;
        if ({vga_r, vga_g, vga_b} !== 12'h000 || vga_hsync !== 1'b1 || vga_vsync !== 1'b1) begin
            nerr++;
            $display("FAIL areset_out: colour=%h hs=%b vs=%b required 000 1 1",
                     {vga_r, vga_g, vga_b}, vga_hsync, vga_vsync);
        end
        nvec++;
        if (dut.r_qx !== 10'd0 || dut.r_qy !== 10'd0 || frame_cnt !== 8'd0) begin
            nerr++;
            $display("FAIL areset_state: qx=%0d qy=%0d cnt=%0d required 0 0 0",
                     dut.r_qx, dut.r_qy, frame_cnt);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_motion();
        test_bounce();
        test_pause_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bounce_square.md
BOUNCE_SQUARE -- requirements
Module: bounce_square

Interface
REQ-001 SHALL have parameter H_RES, default 640: active pixels per line.
REQ-002 SHALL have parameter V_RES, default 480: active lines per frame.
REQ-003 SHALL have parameter Q_SIZE, default 32: square edge length in pixels.
REQ-004 SHALL have parameter SPEED, default 2: pixels moved per frame on each axis.
REQ-005 SHALL have port clk_pix, input, 1 bit: pixel clock; the block's only clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port sx, input, 10 bits: horizontal position from the timing generator.
REQ-008 SHALL have port sy, input, 10 bits: vertical position from the timing generator.
REQ-009 SHALL have port hsync, input, 1 bit: negative-polarity horizontal sync.
REQ-010 SHALL have port vsync, input, 1 bit: negative-polarity vertical sync.
REQ-011 SHALL have port de, input, 1 bit: data enable; high in the active area.
REQ-012 SHALL have port run, input, 1 bit: when high the square moves; when low its position freezes.
REQ-013 SHALL have ports vga_r, vga_g and vga_b, outputs, 4 bits each: pixel colour.
REQ-014 SHALL have ports vga_hsync and vga_vsync, outputs, 1 bit each: delayed sync signals.
REQ-015 SHALL have port frame_cnt, output, 8 bits: frames elapsed.

Function
REQ-016 SHALL generate frame_tick as a one-cycle internal pulse, registered from the condition (sy == V_RES && sx == 0).
- frame_tick therefore fires once per frame, in vertical blanking.
REQ-017 SHALL increment frame_cnt on every frame_tick, regardless of run.
- Wraps 255 -> 0.
REQ-018 SHALL hold the square origin in qx and qy (10 bits each) and direction in dx and dy.
- dx = 1 means moving right; dy = 1 means moving down.
REQ-019 SHALL update qx and qy only on a frame_tick while run = 1.
- Position never changes during active video.
REQ-020 SHALL handle horizontal motion on a tick as follows:
- dx = 1 and qx >= H_RES-Q_SIZE-SPEED: qx <= H_RES-Q_SIZE, dx <= 0.
- dx = 1 otherwise: qx <= qx+SPEED.
- dx = 0 and qx <= SPEED: qx <= 0, dx <= 1.
- dx = 0 otherwise: qx <= qx-SPEED.
REQ-021 SHALL handle vertical motion identically to REQ-020, using qy, dy and V_RES.
REQ-022 SHALL perform all position arithmetic at 11 bits or wider, so that qx+Q_SIZE never overflows.
- Parameter legality: Q_SIZE+SPEED < V_RES <= H_RES.
REQ-023 SHALL register sx, sy, de, hsync and vsync in pipeline stage 1, together with in_sq.
- in_sq = (qx <= sx < qx+Q_SIZE) && (qy <= sy < qy+Q_SIZE).
REQ-024 SHALL register the colour and the delayed syncs in pipeline stage 2, driving all outputs.
REQ-025 SHALL give every output exactly 2 clk_pix cycles of latency relative to its inputs.
- This covers sync, de-derived colour and in_sq.
REQ-026 SHALL select the stage-2 colour as follows:
- de = 0: 0x000.
- de = 1 and in_sq = 1: palette[frame_cnt[5:4]], where palette is {0xFFF, 0xF40, 0x4F4, 0x4CF} for indices 0..3.
- de = 1 and in_sq = 0: 0x137.
REQ-027 SHALL let a run deassertion coinciding with a frame_tick suppress that frame's motion.
- frame_cnt still increments.
REQ-028 SHALL treat input hsync and vsync as pass-through data; neither affects internal state.

Reset
REQ-029 SHALL, while rst is high, force the following values asynchronously:
- qx = 0, qy = 0, dx = 1, dy = 1, frame_cnt = 0, frame_tick = 0.
- All pipeline registers: colour 0x000, syncs 1 (inactive).
REQ-030 SHALL resume normal operation on the first clk_pix edge after rst falls.
- The first valid output appears 2 cycles after the first valid input.
REQ-031 SHALL, if rst asserts mid-line or mid-frame, discard all in-flight pipeline data.
- No partial-frame motion update occurs.

Verification
REQ-032 SHALL verify latency: drive a 640x480 timing source with run = 0 after reset.
- Input hsync falling at sx = 656 -> vga_hsync falls 2 cycles later.
- Pixel (0,0) -> 0xFFF (square, palette index 0) appears 2 cycles after sx = 0, sy = 0.
- Pixel (32,0) -> 0x137.
REQ-033 SHALL verify blanking: for any pixel with de = 0 (for example sx = 700), all colour outputs = 0 two cycles later.
REQ-034 SHALL verify motion: with run = 1 from reset -> after frame ticks 1, 2 and 3, qx = qy = 2, 4, 6.
- frame_cnt = 1, 2, 3.
REQ-035 SHALL verify the right-edge bounce: preload by running until qx = 606, dx = 1.
- Next tick -> qx = 608, dx = 0.
- Following tick -> qx = 606.
- Bottom edge analogous: qy 446 -> 448, dy = 0.
REQ-036 SHALL verify pause and wrap:
- run = 0 for 300 frames -> qx and qy unchanged.
- frame_cnt wraps 255 -> 0.
- Square colour changes every 16 frames, in palette order.
REQ-037 SHALL verify asynchronous reset: assert rst mid-frame at sx = 100, sy = 200, without a clock edge.
- Outputs immediately read colour 0 and syncs 1.
- qx = qy = 0, frame_cnt = 0.
